// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit. Accepts one load/store at a time from
//            the pipeline, stalls upstream while the bus transfer is pending,
//            places store data on the correct byte lanes, extracts and
//            extends load data, and reports misalignment and bus timeouts.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_we/req_size/req_signed/req_addr/req_wdata - request
//            stall                       - freeze PC and upstream registers
//            rsp_valid/rsp_rdata         - one-cycle response, held read data
//            err_align/err_timeout       - error pulses aligned with rsp_valid
//            CPU_MIO/mem_w/Address_out/Data_out/byte_en - bus request side
//            Data_in/MIO_ready           - bus response side
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                err_align,
  output logic                err_timeout,
  output logic                CPU_MIO,
  output logic                mem_w,
  output logic [ADDR_W-1:0]   Address_out,
  output logic [DATA_W-1:0]   Data_out,
  output logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic                MIO_ready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Lanes covered by an access of the given size, before shifting to the offset.
  function automatic logic [NB-1:0] size_lanes(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m[NB-1:0];
  endfunction

  // Expand a per-lane enable into a per-bit mask.
  function automatic logic [DATA_W-1:0] lane_bits(input logic [NB-1:0] lanes);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < NB; i++) begin
      bits[8*i +: 8] = {8{lanes[i]}};
    end
    return bits;
  endfunction

  logic              we_q, signed_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [NB-1:0]     be_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_align_q, err_timeout_q;
  logic [DATA_W-1:0] rdata_q, dout_q;
  logic [ADDR_W-1:0] addr_q;

  logic              misaligned;
  logic              accept, reject, timeout_hit;
  logic [OFF_W-1:0]  req_off;
  logic [NB-1:0]     req_be;
  logic [DATA_W-1:0] req_dout;
  logic [DATA_W-1:0] ld_shifted, ld_mask, ld_topbit, load_data;
  logic              ld_sign;

  assign req_off = req_addr[OFF_W-1:0];

  // A dword is never legal on a 32-bit bus, whatever its address.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  always_comb begin
    req_be   = size_lanes(req_size) << req_off;
    req_dout = (req_wdata & lane_bits(size_lanes(req_size))) << {req_off, 3'b000};
  end

  // Load extraction: align the addressed bytes down to bit 0, then extend.
  // The sign bit is the top bit of the size mask, found without indexing.
  always_comb begin
    ld_shifted = Data_in >> {off_q, 3'b000};
    ld_mask    = lane_bits(size_lanes(size_q));
    ld_topbit  = ld_mask & ~(ld_mask >> 1);
    ld_sign    = signed_q & (|(ld_shifted & ld_topbit));
    load_data  = (ld_shifted & ld_mask) | (ld_sign ? ~ld_mask : '0);
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            reject  = 1'b1;
            state_d = DONE;
          end else begin
            accept  = 1'b1;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (MIO_ready) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      signed_q      <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= '0;
      be_q          <= '0;
      cnt_q         <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      rdata_q       <= '0;
      dout_q        <= '0;
      addr_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        off_q    <= req_off;
        be_q     <= req_be;
        addr_q   <= req_addr;
        dout_q   <= req_dout;
        cnt_q    <= CNT_W'(1);
      end else if (state_q == BUS && !MIO_ready && !timeout_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Response fields are captured only on DONE entry so they hold until the next response.
      if (state_d == DONE && state_q != DONE) begin
        err_align_q   <= reject;
        err_timeout_q <= timeout_hit;
        rdata_q       <= (state_q == BUS && MIO_ready && !we_q) ? load_data : '0;
      end
    end
  end

  assign stall       = ((state_q == IDLE) && req_valid) || (state_q == BUS);
  assign CPU_MIO     = (state_q == BUS);
  assign mem_w       = (state_q == BUS) && we_q;
  assign byte_en     = (state_q == BUS) ? be_q : '0;
  assign Address_out = addr_q;
  assign Data_out    = dout_q;
  assign rsp_valid   = (state_q == DONE);
  assign err_align   = (state_q == DONE) && err_align_q;
  assign err_timeout = (state_q == DONE) && err_timeout_q;
  assign rsp_rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit (DATA_W=32, TIMEOUT=4).
//            Expected values come from an arithmetic reference model of the
//            load/store rules; stimulus mixes directed and random accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, err_align, err_timeout;
  logic [31:0] rsp_rdata;
  logic        CPU_MIO, mem_w;
  logic [31:0] Address_out, Data_out, Data_in;
  logic [3:0]  byte_en;
  logic        MIO_ready;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err_align  (err_align),
    .err_timeout(err_timeout),
    .CPU_MIO    (CPU_MIO),
    .mem_w      (mem_w),
    .Address_out(Address_out),
    .Data_out   (Data_out),
    .byte_en    (byte_en),
    .Data_in    (Data_in),
    .MIO_ready  (MIO_ready)
  );

  always #5 clk = ~clk;

  // One access end to end. rdly = number of BUS cycles with MIO_ready low
  // before it is raised; rdly >= TIMEOUT means the bus never answers.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] din, input int rdly);
    int          sb, off, bus_cycles, done_cyc;
    logic        mis, tmo, in_bus, is_done;
    logic [63:0] m, ld;
    logic [3:0]  exp_be;
    logic [31:0] exp_dout, exp_rdata;
    logic [9:0]  exp_vec, got_vec;
    sb         = 1 << size;
    off        = int'(addr[1:0]);
    mis        = (size == 2'b11) || ((int'(addr[2:0]) % sb) != 0);
    tmo        = !mis && (rdly >= TIMEOUT);
    bus_cycles = mis ? 0 : (tmo ? TIMEOUT : rdly + 1);
    done_cyc   = 1 + bus_cycles;
    m          = (64'd1 << (8 * sb)) - 64'd1;
    exp_be     = 4'(((1 << sb) - 1) << off);
    exp_dout   = 32'(({32'd0, wdata} & m) << (8 * off));
    ld         = ({32'd0, din} >> (8 * off)) & m;
    if (sgn && ld[8*sb-1]) ld = ld | ~m;
    exp_rdata  = (mis || tmo || we) ? 32'd0 : ld[31:0];

    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    Data_in    = din;
    for (int cyc = 0; cyc <= done_cyc; cyc++) begin
      in_bus  = !mis && (cyc >= 1) && (cyc <= bus_cycles);
      is_done = (cyc == done_cyc);
      // Outside BUS the ready line is randomly toggled; it must have no effect.
      MIO_ready = in_bus ? (cyc == rdly + 1) : 1'($urandom_range(0, 1));
      #1;
      exp_vec = {cyc < done_cyc, in_bus, in_bus & we, in_bus ? exp_be : 4'd0,
                 is_done, is_done & mis, is_done & tmo};
      got_vec = {stall, CPU_MIO, mem_w, byte_en, rsp_valid, err_align, err_timeout};
      tests++;
      if (got_vec !== exp_vec) begin
        fails++;
        $display("FAIL ctrl addr=%h cyc=%0d got=%b exp=%b (stall,mio,w,be,rsp,ea,et)",
                 addr, cyc, got_vec, exp_vec);
      end
      if (in_bus) begin
        tests++;
        if ({Address_out, Data_out} !== {addr, exp_dout}) begin
          fails++;
          $display("FAIL busdata cyc=%0d addr got=%h exp=%h dout got=%h exp=%h",
                   cyc, Address_out, addr, Data_out, exp_dout);
        end
      end
      if (is_done) begin
        tests++;
        if (rsp_rdata !== exp_rdata) begin
          fails++;
          $display("FAIL rdata addr=%h size=%0d got=%h exp=%h", addr, size, rsp_rdata, exp_rdata);
        end
      end
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    MIO_ready = 1'b0;
    #1;
    tests++;
    if ({stall, rsp_valid, CPU_MIO, rsp_rdata} !== {3'b000, exp_rdata}) begin
      fails++;
      $display("FAIL hold got stall/rsp/mio=%b%b%b rdata=%h exp 000 rdata=%h",
               stall, rsp_valid, CPU_MIO, rsp_rdata, exp_rdata);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; Data_in = '0; MIO_ready = 1'b0;
    #3;  // before any clock edge: asynchronous reset must already hold
    tests++;
    if ({stall, rsp_valid, rsp_rdata, err_align, err_timeout, CPU_MIO, mem_w,
         byte_en, Address_out, Data_out} !== '0) begin
      fails++;
      $display("FAIL reset outputs not zero: rsp=%b rdata=%h mio=%b be=%b addr=%h dout=%h",
               rsp_valid, rsp_rdata, CPU_MIO, byte_en, Address_out, Data_out);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_load_word();
    run_txn(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 2);
    tests++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL load_word got=%h exp=deadbeef", rsp_rdata);
    end
  endtask

  task automatic test_load_byte();
    run_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80AABBCC, 0);
    tests++;
    if (rsp_rdata !== 32'hFFFFFF80) begin
      fails++; $display("FAIL load_byte_s got=%h exp=ffffff80", rsp_rdata);
    end
    run_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80AABBCC, 1);
    tests++;
    if (rsp_rdata !== 32'h00000080) begin
      fails++; $display("FAIL load_byte_u got=%h exp=00000080", rsp_rdata);
    end
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFF1234, 32'h55555555, 1);
    tests++;
    if ({Data_out, Address_out, rsp_rdata} !== {32'h12340000, 32'h202, 32'h0}) begin
      fails++;
      $display("FAIL store_half dout=%h addr=%h rdata=%h exp 12340000/202/0",
               Data_out, Address_out, rsp_rdata);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h205, 32'hABCD, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h12345678, 10);
    run_txn(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h87654321, TIMEOUT - 1);
  endtask

  task automatic test_reset_mid_bus();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h300; Data_in = 32'hA5A5A5A5; MIO_ready = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    #1;
    tests++;
    if (CPU_MIO !== 1'b1) begin
      fails++; $display("FAIL midbus_pre CPU_MIO got=%b exp=1", CPU_MIO);
    end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    tests++;
    if ({CPU_MIO, mem_w, byte_en, rsp_valid, Address_out, Data_out} !== '0) begin
      fails++;
      $display("FAIL midbus_rst mio=%b be=%b rsp=%b addr=%h exp all 0",
               CPU_MIO, byte_en, rsp_valid, Address_out);
    end
    repeat (3) begin
      @(posedge clk); #2;
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL midbus_norsp rsp_valid got=%b exp=0", rsp_valid);
      end
    end
    rst = 1'b1;
    run_txn(1'b0, 2'b01, 1'b1, 32'h306, 32'h0, 32'h8001FFFF, 0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000AB, 32'h0, 0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CD, 32'h0, 0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hBEEF0000, 0);
  endtask

  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      run_txn(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
              $urandom, $urandom, int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
